// File: rtl/uart_rx_if.sv
// Picorv32-style mem_* bus bundle for the UART receiver register window.
interface uart_rx_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a small FIFO, polled through a DATA/STATUS register pair
// on the mem_* bus. Flags ovr/ferr are sticky until any write.
module uart_rx #(
    parameter int BAUD_DIVIDER = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      enable,
    uart_rx_if.slave  bus,
    input  logic      serialIn
);
    localparam int CW = $clog2(BAUD_DIVIDER + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD = CW'(BAUD_DIVIDER);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIVIDER / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic          push, ferr_set, expire;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full, empty, pop, push_ok, ovr_set;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;

    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          req, clr;
    logic          unused_bus;

    assign unused_bus = ^{bus.mem_instr, bus.mem_wdata, bus.mem_addr[31:3], bus.mem_addr[1:0]};

    // Synchroniser and previous-sample register for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= serialIn;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign expire = (cnt_q == CW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = BAUD;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = BAUD;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            default: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    push     = rx_s_q;
                    ferr_set = !rx_s_q;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // FIFO status and bus decode; a pop frees a slot for a same-cycle push even when full.
    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        req     = enable && bus.mem_valid && !ready_q;
        ready_d = req;
        rdata_d = 32'd0;
        pop     = 1'b0;
        clr     = 1'b0;
        if (req) begin
            if (|bus.mem_wstrb) begin
                clr = 1'b1;
            end else if (!bus.mem_addr[2]) begin
                rdata_d = {23'd0, !empty, (empty ? 8'd0 : mem_q[rd_ptr_q])};
                pop     = !empty;
            end else begin
                rdata_d = {21'd0, ferr_q, ovr_q, !empty, 8'd0};
            end
        end
        ovr_d  = ovr_set  || (ovr_q  && !clr);
        ferr_d = ferr_set || (ferr_q && !clr);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
endmodule
